// File: rtl/reel_spin_scheduler.sv
// Reel spin scheduler: spins every reel on a start request and releases them
// left to right, each stopping on a latched odd (symbol) position.
module reel_spin_scheduler #(
  parameter int N_REELS  = 3,
  parameter int MIN_SPIN = 48,
  parameter int STAGGER  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   start,
  input  logic [N_REELS*5-1:0]   target,
  output logic [N_REELS*5-1:0]   p_reel,
  output logic [N_REELS-1:0]     reel_spinning,
  output logic                   busy,
  output logic                   done
);

  localparam int TW = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SPIN   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  // state is the FSM register; bind checkers to it directly.
  state_t         state, state_d;
  logic [TW-1:0]  timer, timer_d;
  logic [4:0]     pos   [N_REELS];
  logic [4:0]     pos_d [N_REELS];
  logic [4:0]     tgt   [N_REELS];
  logic [4:0]     tgt_d [N_REELS];
  logic [N_REELS-1:0] spin, spin_d;
  logic [N_REELS-1:0] armed;

  // start is a one-cycle request with no ready: it is accepted only in IDLE
  // (busy low) and silently dropped while busy is high.

  always_comb begin
    armed = '0;
    for (int i = 0; i < N_REELS; i++) begin
      armed[i] = ({16'd0, timer} >= 32'(MIN_SPIN + i * STAGGER));
    end
  end

  always_comb begin
    state_d = state;
    timer_d = timer;
    spin_d  = spin;
    for (int i = 0; i < N_REELS; i++) begin
      pos_d[i] = pos[i];
      tgt_d[i] = tgt[i];
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          // Forcing the LSB keeps every stop on a symbol, never a blank gap.
          for (int i = 0; i < N_REELS; i++) begin
            tgt_d[i] = target[5*i +: 5] | 5'd1;
          end
          timer_d = '0;
          spin_d  = '1;
          state_d = S_SPIN;
        end
      end

      S_SPIN: begin
        if (tick) begin
          if (timer != {TW{1'b1}}) begin
            timer_d = timer + TW'(1);
          end
          // Stop test uses the pre-tick position: a reel already on target
          // when it becomes armed halts without moving.
          for (int i = 0; i < N_REELS; i++) begin
            if (spin[i]) begin
              if (armed[i] && (pos[i] == tgt[i])) begin
                spin_d[i] = 1'b0;
              end else begin
                pos_d[i] = pos[i] + 5'd1;
              end
            end
          end
          if (spin_d == '0) begin
            state_d = S_FINISH;
          end
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      timer <= '0;
      spin  <= '0;
      for (int i = 0; i < N_REELS; i++) begin
        pos[i] <= 5'd1;
        tgt[i] <= 5'd1;
      end
    end else begin
      state <= state_d;
      timer <= timer_d;
      spin  <= spin_d;
      for (int i = 0; i < N_REELS; i++) begin
        pos[i] <= pos_d[i];
        tgt[i] <= tgt_d[i];
      end
    end
  end

  always_comb begin
    p_reel = '0;
    for (int i = 0; i < N_REELS; i++) begin
      p_reel[5*i +: 5] = pos[i];
    end
  end

  assign reel_spinning = spin;
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_FINISH);

endmodule
